// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci LFSR with step counter, wrap pulse and lockup flag.
//   Parameters: WIDTH (3..32), TAPS (feedback mask), SEED (reset value).
//   Ports: clk, rst (sync, active-high), en (step), load/seed_in (reload),
//          out (state), bit_out (out MSB), step_cnt (steps since reset/load),
//          wrap (pulse when the state returns to start), lockup (out == 0).
//   Macro LFSR_GEN_LOCKUP_RECOVER_EN: a step taken from all-zero reloads SEED.
module lfsr_gen #(
   parameter int                 WIDTH = 8,
   parameter logic [WIDTH-1:0]   TAPS  = WIDTH'(8'hB8),
   parameter logic [WIDTH-1:0]   SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] out,
   output logic             bit_out,
   output logic [WIDTH-1:0] step_cnt,
   output logic             wrap,
   output logic             lockup
);
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
   localparam bit RECOVER = 1'b1;
`else
   localparam bit RECOVER = 1'b0;
`endif
   logic [WIDTH-1:0] state_q, state_d, start_q, start_d, cnt_q, cnt_d, nxt;
   logic             wrap_q, wrap_d;
   always_comb begin
      nxt     = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
      state_d = state_q;
      start_d = start_q;
      cnt_d   = cnt_q;
      wrap_d  = 1'b0;
      if (load) begin
         state_d = seed_in;
         start_d = seed_in;
         cnt_d   = '0;
      end else if (en) begin
         if (RECOVER && state_q == '0) begin
            state_d = SEED;
            start_d = SEED;
            cnt_d   = '0;
         end else begin
            // Returning to start ends a period: pulse wrap and restart the count.
            state_d = nxt;
            wrap_d  = (nxt == start_q);
            cnt_d   = wrap_d ? '0 : cnt_q + WIDTH'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
         start_q <= SEED;
         cnt_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         cnt_q   <= cnt_d;
         wrap_q  <= wrap_d;
      end
   end
   assign out      = state_q;
   assign bit_out  = state_q[WIDTH-1];
   assign step_cnt = cnt_q;
   assign wrap     = wrap_q;
   assign lockup   = (state_q == '0);
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scoreboard bench for lfsr_gen (4-bit TAPS=C instance plus a default-parameter instance).
module tb_lfsr_gen;
   typedef struct {
      logic [3:0] out;
      logic [3:0] cnt;
      logic       wrap;
      logic       chk_cnt;
   } exp_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1, load = 1'b0, en = 1'b0;
   logic [3:0] seed_in = '0;
   logic [3:0] out, step_cnt;
   logic       bit_out, wrap, lockup;
   logic       r8 = 1'b0, l8 = 1'b0, e8 = 1'b0;
   logic [7:0] s8 = '0, out8, cnt8;
   logic       bit8, wrap8, lock8;
   int         checks = 0, errors = 0;
   exp_t       q[$];
   logic [3:0] m_out = 4'h1, m_start = 4'h1, m_cnt = '0;
   logic       m_wrap = 1'b0;
   logic [3:0] seq [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};

   lfsr_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut (
      .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
      .out(out), .bit_out(bit_out), .step_cnt(step_cnt), .wrap(wrap), .lockup(lockup));

   lfsr_gen dut8 (
      .clk(clk), .rst(r8), .en(e8), .load(l8), .seed_in(s8),
      .out(out8), .bit_out(bit8), .step_cnt(cnt8), .wrap(wrap8), .lockup(lock8));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Successor taken from the hand-computed period table; all-zero maps to itself.
   function automatic logic [3:0] succ(input logic [3:0] x);
      for (int i = 0; i < 15; i++)
         if (seq[i] == x) return seq[i+1];
      return 4'h0;
   endfunction

   task automatic drive(input logic r, input logic l, input logic e, input logic [3:0] s);
      logic [3:0] nx;
      logic       cc;
      @(negedge clk);
      rst = r; load = l; en = e; seed_in = s;
      cc = 1'b1;
      if (r) begin
         m_out = 4'h1; m_start = 4'h1; m_cnt = '0; m_wrap = 1'b0;
      end else if (l) begin
         m_out = s; m_start = s; m_cnt = '0; m_wrap = 1'b0;
      end else if (e) begin
`ifdef LFSR_GEN_LOCKUP_RECOVER_EN
         if (m_out == 4'h0) begin
            m_out = 4'h1; m_start = 4'h1; m_cnt = '0; m_wrap = 1'b0;
         end else begin
`else
         begin
            if (m_out == 4'h0) cc = 1'b0;
`endif
            nx     = succ(m_out);
            m_wrap = (nx == m_start);
            m_cnt  = m_wrap ? 4'h0 : m_cnt + 4'h1;
            m_out  = nx;
         end
      end else begin
         m_wrap = 1'b0;
      end
      q.push_back('{out: m_out, cnt: m_cnt, wrap: m_wrap, chk_cnt: cc});
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("out", 32'(out), 32'(e.out));
         chk("bit_out", 32'(bit_out), 32'(e.out[3]));
         chk("wrap", 32'(wrap), 32'(e.wrap));
         chk("lockup", 32'(lockup), 32'(e.out == 4'h0));
         if (e.chk_cnt) chk("step_cnt", 32'(step_cnt), 32'(e.cnt));
      end
   end

   initial begin
      // Default-parameter instance: rst beats load and en mid-sequence.
      @(negedge clk); r8 = 1'b1;
      @(negedge clk); r8 = 1'b0; l8 = 1'b1; s8 = 8'h55;
      @(negedge clk); l8 = 1'b0; e8 = 1'b1;
      @(negedge clk); @(negedge clk);
      r8 = 1'b1; l8 = 1'b1; e8 = 1'b1; s8 = 8'hA7;
      @(posedge clk); #1;
      chk("rst_prio_out8", 32'(out8), 32'h01);
      chk("rst_prio_cnt8", 32'(cnt8), 32'h0);
      chk("rst_prio_wrap8", 32'(wrap8), 32'h0);
      @(negedge clk); r8 = 1'b0; l8 = 1'b0; e8 = 1'b0;
      // 4-bit instance: reset, then two full periods plus a bit.
      drive(1, 0, 0, 4'h0);
      drive(1, 0, 1, 4'h0);
      for (int i = 0; i < 33; i++) drive(0, 0, 1, 4'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 4'h0);
      // Load wins over en; wrap 15 steps later.
      drive(0, 1, 1, 4'h9);
      for (int i = 0; i < 17; i++) drive(0, 0, 1, 4'h0);
      // Reset mid-sequence overriding load and en.
      drive(0, 0, 1, 4'h0);
      drive(1, 1, 1, 4'h5);
      // Random en.
      for (int i = 0; i < 40; i++) drive(0, 0, 1'($urandom_range(0, 1)), 4'h0);
      // Zero-state behaviour.
      drive(0, 1, 0, 4'h0);
      for (int i = 0; i < 3; i++) drive(0, 0, 1, 4'h0);
      drive(0, 0, 0, 4'h0);
      drive(1, 0, 0, 4'h0);
      @(negedge clk); rst = 1'b0; en = 1'b0;
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
